pe_uno_seq: RTL

- Sequencer for the PE datapath; a single instance drives the mode select and coefficient stream of one PE column.
- Accepts one operation request at a time and holds the PE mode for its duration: gemm, div, exp or log.
- For unary modes it streams stored polynomial coefficients, highest index first, onto the PE coefficient input. The PE evaluates this Horner-style as mac*var + wc.
- For gemm it holds the mode for len cycles and leaves the weight path to the weight loader.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_uno_seq_if.sv | 29 ++
 rtl/pe_coef_rf.sv | 37 +++
 rtl/pe_uno_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the PE unary/gemm sequencer.
package pe_pkg;

  localparam int MUL_BW_DEF    = 16;
  localparam int TERM_MAX_DEF  = 8;
  localparam int LEN_BW_DEF    = 4;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } uno_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic is_unary(input logic [1:0] mode);
    return mode != GEMM;
  endfunction

endpackage

// File: rtl/pe_uno_seq_if.sv
// Request and coefficient-config bus between a requester and pe_uno_seq.
interface pe_uno_seq_if import pe_pkg::*; #(
  parameter int MUL_BW   = MUL_BW_DEF,
  parameter int TERM_MAX = TERM_MAX_DEF,
  parameter int LEN_BW   = LEN_BW_DEF
);
  localparam int IDX_BW = $clog2(TERM_MAX);

  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_mode;
  logic [LEN_BW-1:0]        req_len;
  logic                     cfg_we;
  logic [1:0]               cfg_mode;
  logic [IDX_BW-1:0]        cfg_idx;
  logic signed [MUL_BW-1:0] cfg_data;
  logic                     cfg_err;

  modport master (
    output req_valid, req_mode, req_len, cfg_we, cfg_mode, cfg_idx, cfg_data,
    input  req_ready, cfg_err
  );

  modport slave (
    input  req_valid, req_mode, req_len, cfg_we, cfg_mode, cfg_idx, cfg_data,
    output req_ready, cfg_err
  );

endinterface

// File: rtl/pe_coef_rf.sv
// Coefficient tables for div/exp/log: one write port, one combinational read port.
module pe_coef_rf import pe_pkg::*; #(
  parameter int MUL_BW   = MUL_BW_DEF,
  parameter int TERM_MAX = TERM_MAX_DEF,
  localparam int IDX_BW  = $clog2(TERM_MAX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [1:0]               wr_mode,
  input  logic [IDX_BW-1:0]        wr_idx,
  input  logic signed [MUL_BW-1:0] wr_data,
  input  logic [1:0]               rd_mode,
  input  logic [IDX_BW-1:0]        rd_idx,
  output logic signed [MUL_BW-1:0] rd_data
);

  logic signed [MUL_BW-1:0] mem [1:3][TERM_MAX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned m = 1; m <= 3; m++)
        for (int unsigned i = 0; i < TERM_MAX; i++)
          mem[m][i] <= '0;
    end else if (we && wr_mode != GEMM) begin
      mem[wr_mode][wr_idx] <= wr_data;
    end
  end

  // Table 00 does not exist; reads of it return zero.
  always_comb begin
    rd_data = '0;
    if (rd_mode != GEMM && {1'b0, rd_idx} < (IDX_BW+1)'(TERM_MAX))
      rd_data = mem[rd_mode][rd_idx];
  end

endmodule

// File: rtl/pe_uno_seq.sv
// PE column sequencer: holds mode for gemm/div/exp/log and streams unary coefficients.
// Optional busy-cycle counter enabled by PE_UNO_SEQ_PERF_EN.
module pe_uno_seq import pe_pkg::*; #(
  parameter int MUL_BW    = MUL_BW_DEF,
  parameter int TERM_MAX  = TERM_MAX_DEF,
  parameter int LEN_BW    = LEN_BW_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pe_uno_seq_if.slave              bus,
  output logic [1:0]               gemm_uno,
  output logic signed [MUL_BW-1:0] wc_o,
  output logic                     wc_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err,
  output logic [31:0]              perf_cnt
);

  localparam int IDX_BW  = $clog2(TERM_MAX);
  localparam int DCNT_BW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  seq_state_e               state, state_n;
  uno_mode_e                mode_q, mode_n;
  logic [LEN_BW-1:0]        cnt, cnt_n;
  logic [DCNT_BW-1:0]       dcnt, dcnt_n;
  logic [1:0]               gemm_uno_n;
  logic signed [MUL_BW-1:0] wc_n;
  logic                     wc_valid_n, done_n, len_err_n, busy_n;
  logic                     cfg_err_q, cfg_err_n;

  logic                     idle, accept, unary_req, len_zero, len_over, idx_ok, wr_ok;
  logic [LEN_BW-1:0]        eff_len;
  logic [1:0]               rd_mode;
  logic [IDX_BW-1:0]        rd_idx;
  logic signed [MUL_BW-1:0] rf_data, coef_rd;

  assign idle      = (state == IDLE);
  assign accept    = bus.req_valid && idle;
  assign unary_req = is_unary(bus.req_mode);
  assign len_zero  = (bus.req_len == '0);
  assign len_over  = unary_req && (bus.req_len > LEN_BW'(TERM_MAX));
  assign eff_len   = len_over ? LEN_BW'(TERM_MAX) : bus.req_len;
  assign idx_ok    = {1'b0, bus.cfg_idx} < (IDX_BW+1)'(TERM_MAX);
  assign wr_ok     = bus.cfg_we && idle && (bus.cfg_mode != GEMM) && idx_ok;
  assign cfg_err_n = bus.cfg_we && !wr_ok;

  assign bus.req_ready = idle;
  assign bus.cfg_err   = cfg_err_q;

  // In IDLE the read port looks ahead at the first term of the incoming request.
  assign rd_mode = idle ? bus.req_mode : mode_q;
  assign rd_idx  = idle ? IDX_BW'(eff_len - LEN_BW'(1)) : IDX_BW'(cnt - LEN_BW'(1));

  pe_coef_rf #(
    .MUL_BW   (MUL_BW),
    .TERM_MAX (TERM_MAX)
  ) u_coef_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_ok),
    .wr_mode (bus.cfg_mode),
    .wr_idx  (bus.cfg_idx),
    .wr_data (bus.cfg_data),
    .rd_mode (rd_mode),
    .rd_idx  (rd_idx),
    .rd_data (rf_data)
  );

  // A write landing on the same edge as the accept must be the value issued first.
  assign coef_rd = (wr_ok && bus.cfg_mode == rd_mode && bus.cfg_idx == rd_idx)
                   ? bus.cfg_data : rf_data;

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    cnt_n      = cnt;
    dcnt_n     = dcnt;
    gemm_uno_n = gemm_uno;
    wc_n       = '0;
    wc_valid_n = 1'b0;
    done_n     = 1'b0;
    len_err_n  = len_err;
    unique case (state)
      IDLE: begin
        gemm_uno_n = GEMM;
        if (accept) begin
          len_err_n = len_zero || len_over;
          if (len_zero) begin
            mode_n  = GEMM;
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            mode_n     = uno_mode_e'(bus.req_mode);
            gemm_uno_n = bus.req_mode;
            cnt_n      = eff_len - LEN_BW'(1);
            state_n    = ISSUE;
            if (unary_req) begin
              wc_n       = coef_rd;
              wc_valid_n = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (cnt == '0) begin
          if (DRAIN_CYC == 0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = DRAIN;
            dcnt_n  = DCNT_BW'(DRAIN_CYC - 1);
          end
        end else begin
          cnt_n = cnt - LEN_BW'(1);
          if (is_unary(mode_q)) begin
            wc_n       = coef_rd;
            wc_valid_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          dcnt_n = dcnt - DCNT_BW'(1);
        end
      end
      DONE: begin
        state_n    = IDLE;
        gemm_uno_n = GEMM;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= GEMM;
      cnt       <= '0;
      dcnt      <= '0;
      gemm_uno  <= '0;
      wc_o      <= '0;
      wc_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      cnt       <= cnt_n;
      dcnt      <= dcnt_n;
      gemm_uno  <= gemm_uno_n;
      wc_o      <= wc_n;
      wc_valid  <= wc_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      len_err   <= len_err_n;
      cfg_err_q <= cfg_err_n;
    end
  end

`ifdef PE_UNO_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cnt <= '0;
    else if (busy && perf_cnt != '1)
      perf_cnt <= perf_cnt + 32'd1;
  end
`else
  assign perf_cnt = '0;
`endif

endmodule
